// File: rtl/serial_sub_pkg.sv
// Shared constants and state type for the bit-serial subtractor.
package serial_sub_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_t;

endpackage

// File: rtl/serial_subtractor_dfsub.sv
// Combinational full-subtractor cell: out = in1 - in2 - bin, bout = borrow.
// Zero latency; no handshake.
module dfsub (
  input  logic in1,
  input  logic in2,
  input  logic bin,
  output logic out,
  output logic bout
);

  assign out  = in1 ^ in2 ^ bin;
  assign bout = (~in1 & in2) | (~(in1 ^ in2) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first; done_valid rises WIDTH edges after the accept edge.
// Backpressure: result held in DONE until done_ready; start_ready only in IDLE.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             d_bit;
  logic             bo_bit;

  dfsub u_dfsub (
    .in1  (ra_q[0]),
    .in2  (rb_q[0]),
    .bin  (br_q),
    .out  (d_bit),
    .bout (bo_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          ra_d    = a;
          rb_d    = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        res_d = {d_bit, res_q[WIDTH-1:1]};
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        br_d  = bo_bit;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (done_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign done_valid  = (state_q == ST_DONE);
  assign diff        = done_valid ? res_q : '0;
  assign borrow      = done_valid & br_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, corner sequences, random ops vs arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         borrow;
  logic         done_valid;
  logic         done_ready;
  logic         busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .diff        (diff),
    .borrow      (borrow),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         brw;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // All tasks are entered and left just after a falling edge.
  task automatic do_accept(input logic [W-1:0] av, input logic [W-1:0] bv, output time t_acc);
    start_valid = 1'b1;
    a = av;
    b = bv;
    check("start_ready_idle", {31'd0, start_ready}, 32'd1);
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    start_valid = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  // Scrambles a/b every cycle while waiting, so the result must come from the accepted operands.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done_valid && lat < 4 * W) begin
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, W);
  endtask

  task automatic take_done();
    done_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    done_ready = 1'b0;
    check("idle_start_ready", {31'd0, start_ready}, 32'd1);
    check("idle_done_valid", {31'd0, done_valid}, 32'd0);
    check("idle_diff_zero", {24'd0, diff}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    time t_acc, t_prev;
    int lat;
    logic [W:0] model;
    logic [W-1:0] hold_diff;
    logic hold_brw;

    tbl[0] = '{a: 8'd100,  b: 8'd37,   diff: 8'h3F, brw: 1'b0};
    tbl[1] = '{a: 8'h05,   b: 8'h0A,   diff: 8'hFB, brw: 1'b1};
    tbl[2] = '{a: 8'hFF,   b: 8'hFF,   diff: 8'h00, brw: 1'b0};
    tbl[3] = '{a: 8'h00,   b: 8'hFF,   diff: 8'h01, brw: 1'b1};
    tbl[4] = '{a: 8'd200,  b: 8'd55,   diff: 8'd145, brw: 1'b0};
    tbl[5] = '{a: 8'h80,   b: 8'h01,   diff: 8'h7F, brw: 1'b0};

    rst_n = 1'b0;
    start_valid = 1'b0;
    done_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("rst_start_ready", {31'd0, start_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done_valid", {31'd0, done_valid}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_borrow", {31'd0, borrow}, 32'd0);
    rst_n = 1'b1;

    // Table vectors, back to back with an always-ready consumer.
    t_prev = 0;
    for (int i = 0; i < 6; i++) begin
      do_accept(tbl[i].a, tbl[i].b, t_acc);
      if (i > 0) check("spacing", 32'(t_acc - t_prev), 32'((W + 2) * 10));
      t_prev = t_acc;
      wait_done(lat);
      check("tbl_diff", {24'd0, diff}, {24'd0, tbl[i].diff});
      check("tbl_borrow", {31'd0, borrow}, {31'd0, tbl[i].brw});
      take_done();
    end

    // Consumer backpressure with a competing start request.
    do_accept(8'd100, 8'd37, t_acc);
    wait_done(lat);
    start_valid = 1'b1;
    a = 8'h05;
    b = 8'h0A;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_done_valid", {31'd0, done_valid}, 32'd1);
      check("bp_start_ready", {31'd0, start_ready}, 32'd0);
      check("bp_diff", {24'd0, diff}, 32'h3F);
      check("bp_borrow", {31'd0, borrow}, 32'd0);
    end
    done_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    done_ready = 1'b0;
    check("bp_release_ready", {31'd0, start_ready}, 32'd1);
    check("bp_release_valid", {31'd0, done_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    check("bp_new_busy", {31'd0, busy}, 32'd1);
    wait_done(lat);
    check("bp_new_diff", {24'd0, diff}, 32'hFB);
    check("bp_new_borrow", {31'd0, borrow}, 32'd1);
    take_done();

    // Reset after the third SHIFT edge.
    do_accept(8'h33, 8'h44, t_acc);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done_valid", {31'd0, done_valid}, 32'd0);
    check("midrst_diff", {24'd0, diff}, 32'd0);
    check("midrst_borrow", {31'd0, borrow}, 32'd0);
    check("midrst_start_ready", {31'd0, start_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_accept(8'd200, 8'd55, t_acc);
    wait_done(lat);
    check("postrst_diff", {24'd0, diff}, 32'd145);
    check("postrst_borrow", {31'd0, borrow}, 32'd0);
    take_done();

    // Random operations against plain arithmetic, with random consumer stalls.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      int stall;
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 8 == 0) rb = ra;
      model = {1'b0, ra} - {1'b0, rb};
      do_accept(ra, rb, t_acc);
      wait_done(lat);
      hold_diff = diff;
      hold_brw = borrow;
      check("rnd_diff", {24'd0, diff}, {24'd0, model[W-1:0]});
      check("rnd_borrow", {31'd0, borrow}, {31'd0, model[W]});
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (stall > 0) begin
        check("rnd_hold_diff", {24'd0, diff}, {24'd0, hold_diff});
        check("rnd_hold_borrow", {31'd0, borrow}, {31'd0, hold_brw});
      end
      take_done();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
